// File: rtl/step_sequencer_if.sv
// Command/status bundle for the stepper-motor step sequencer.
// The master side issues moves and aborts. The slave side (the sequencer)
// reports coil drive and progress.
interface step_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic        cmd_half;
  logic        abort;
  logic [3:0]  coils;
  logic        busy;
  logic        done;
  logic [15:0] steps_done;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_half, abort,
    input  cmd_ready, coils, busy, done, steps_done
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_half, abort,
    output cmd_ready, coils, busy, done, steps_done
  );
endinterface

// File: rtl/step_sequencer.sv
// Trapezoidal-profile stepper sequencer.
// A move starts at MAX_PERIOD and shortens the step period by ACC_STEP on each
// step until it reaches MIN_PERIOD. It then cruises, and lengthens the period
// again over the final ramp_cnt steps so the motor stops as gently as it started.
// The coil phase index is kept between moves, so the rotor holds its position.
module step_sequencer #(
  parameter logic [20:0] MIN_PERIOD = 21'd5000,
  parameter logic [20:0] MAX_PERIOD = 21'd50000,
  parameter logic [20:0] ACC_STEP   = 21'd500
) (
  input  logic            clk,
  input  logic            rst,
  step_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [3:0]  coils_q, coils_d;
  logic [20:0] timer_q, timer_d;
  logic [20:0] period_q, period_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] ramp_q, ramp_d;
  logic [15:0] steps_done_q, steps_done_d;
  logic        dir_q, dir_d;
  logic        half_q, half_d;
  logic        done_q, busy_q, ready_q;

  logic [2:0]  phase_inc;
  logic [15:0] rem_next;
  logic [15:0] abort_rem;
  logic [21:0] period_up;
  logic        accel_floor;

  // Energised-coil pattern for each half-step position (A, B, A', B').
  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Next-state logic: command accept, step timing, ramp profile and abort.
  always_comb begin
    // NOTE: every _d takes its _q value first, so paths that do not assign it
    // simply hold state and no latch is inferred.
    state_d      = state_q;
    phase_d      = phase_q;
    timer_d      = timer_q;
    period_d     = period_q;
    remaining_d  = remaining_q;
    ramp_d       = ramp_q;
    steps_done_d = steps_done_q;
    dir_d        = dir_q;
    half_d       = half_q;

    phase_inc   = half_q ? 3'd1 : 3'd2;
    rem_next    = remaining_q - 16'd1;
    abort_rem   = (ramp_q < remaining_q) ? ramp_q : remaining_q;
    // The extra top bit keeps the ramp arithmetic from wrapping near either limit.
    period_up   = {1'b0, period_q} + {1'b0, ACC_STEP};
    accel_floor = ({1'b0, period_q} <= ({1'b0, MIN_PERIOD} + {1'b0, ACC_STEP}));

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          remaining_d  = bus.cmd_steps;
          dir_d        = bus.cmd_dir;
          half_d       = bus.cmd_half;
          period_d     = MAX_PERIOD;
          timer_d      = '0;
          ramp_d       = '0;
          steps_done_d = '0;
          state_d      = (bus.cmd_steps == 16'd0) ? S_DONE : S_ACCEL;
        end
      end

      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (bus.abort && (state_q != S_DECEL)) begin
          // Stop within the distance it took to speed up; this cycle's step is dropped.
          timer_d     = '0;
          remaining_d = abort_rem;
          state_d     = (abort_rem == 16'd0) ? S_DONE : S_DECEL;
        end else if (timer_q == period_q - 21'd1) begin
          timer_d      = '0;
          phase_d      = dir_q ? (phase_q + phase_inc) : (phase_q - phase_inc);
          remaining_d  = rem_next;
          steps_done_d = steps_done_q + 16'd1;
          if (rem_next == 16'd0) begin
            state_d = S_DONE;
          end else if (rem_next <= ramp_q) begin
            state_d  = S_DECEL;
            period_d = (period_up >= {1'b0, MAX_PERIOD}) ? MAX_PERIOD : period_up[20:0];
            ramp_d   = (ramp_q == 16'd0) ? 16'd0 : ramp_q - 16'd1;
          end else if (state_q == S_ACCEL) begin
            ramp_d = ramp_q + 16'd1;
            if (accel_floor) begin
              period_d = MIN_PERIOD;
              state_d  = S_CRUISE;
            end else begin
              period_d = period_q - ACC_STEP;
            end
          end
        end else begin
          timer_d = timer_q + 21'd1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    coils_d = coil_pattern(phase_d);
  end

  // State registers with synchronous reset; the status outputs are decoded from
  // the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    // NOTE: flops take non-blocking assignments only, so every flop samples
    // values from before this edge, whatever order the statements are in.
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 3'd0;
      coils_q      <= 4'b1000;
      timer_q      <= '0;
      period_q     <= MAX_PERIOD;
      remaining_q  <= '0;
      ramp_q       <= '0;
      steps_done_q <= '0;
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      coils_q      <= coils_d;
      timer_q      <= timer_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      ramp_q       <= ramp_d;
      steps_done_q <= steps_done_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      done_q       <= (state_d == S_DONE);
      busy_q       <= (state_d != S_IDLE);
      ready_q      <= (state_d == S_IDLE);
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.coils      = coils_q;
  assign bus.steps_done = steps_done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer with a short ramp (4/10/2).
// A step-level reference model predicts when each step occurs, the coil
// pattern after it, and when done pulses. A negedge monitor records what the
// DUT actually does.
module tb_step_sequencer;
  localparam int MIN = 4;
  localparam int MAX = 10;
  localparam int ACC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  step_sequencer_if bus_if ();

  step_sequencer #(
    .MIN_PERIOD(21'd4),
    .MAX_PERIOD(21'd10),
    .ACC_STEP  (21'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycle stamp: the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log each new step (time and coils) and each done pulse.
  int          obs_t[$];
  logic [3:0]  obs_coil[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] prev_sd  = '0;
  always @(negedge clk) begin
    if (bus_if.steps_done != prev_sd && bus_if.steps_done != 16'd0) begin
      obs_t.push_back(cyc);
      obs_coil.push_back(bus_if.coils);
    end
    prev_sd = bus_if.steps_done;
    if (bus_if.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference model.
  logic [3:0] coil_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int         model_phase = 0;
  int         exp_off[$];
  logic [3:0] exp_coil[$];
  int         exp_done_off = 0;

  // Predicts one move at step granularity. abort_k is the number of steps
  // issued before abort (-1 for no abort). abort_d is how many cycles after
  // that step (or after accept) abort is sampled. All times are relative to
  // the accept edge.
  function automatic void model_move(input int n, input bit dir, input bit half,
                                     input int abort_k, input int abort_d);
    int period, ramp, rem, t, issued, sz, iv;
    bit cruise, decel;
    period = MAX; ramp = 0; rem = n; t = 0; issued = 0;
    sz = half ? 1 : 2;
    cruise = 0; decel = 0;
    exp_off.delete();
    exp_coil.delete();
    while (rem > 0) begin
      iv = period;
      if (issued == abort_k && !decel) begin
        rem   = (rem < ramp) ? rem : ramp;
        decel = 1;
        if (rem == 0) begin
          exp_done_off = t + abort_d;
          return;
        end
        iv = abort_d + period;
      end
      t += iv;
      issued++;
      rem--;
      model_phase = (model_phase + (dir ? sz : 8 - sz)) % 8;
      exp_off.push_back(t);
      exp_coil.push_back(coil_tab[model_phase]);
      if (rem == 0) break;
      if (rem <= ramp) begin
        decel  = 1;
        period = (period + ACC > MAX) ? MAX : period + ACC;
        ramp   = (ramp > 0) ? ramp - 1 : 0;
      end else if (!cruise && !decel) begin
        ramp++;
        if (period - ACC <= MIN) begin
          period = MIN;
          cruise = 1;
        end else begin
          period = period - ACC;
        end
      end
    end
    exp_done_off = t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.abort     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_phase = 0;
  endtask

  // Runs one move and checks it against the model. With poke set, a second
  // command is offered while the first is busy; it must be ignored.
  task automatic run_move(input string name, input int n, input bit dir, input bit half,
                          input int abort_k, input int abort_d, input bit poke);
    int acc, budget, m;
    model_move(n, dir, half, abort_k, abort_d);
    @(negedge clk);
    obs_t.delete();
    obs_coil.delete();
    done_cnt = 0;
    check({name, " ready_before"}, 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_steps = 16'(n);
    bus_if.cmd_dir   = dir;
    bus_if.cmd_half  = half;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    bus_if.cmd_valid = 1'b0;
    check({name, " busy_after_accept"}, 32'(bus_if.busy), 32'd1);
    check({name, " ready_after_accept"}, 32'(bus_if.cmd_ready), 32'd0);

    if (poke) begin
      bus_if.cmd_steps = 16'd7;
      bus_if.cmd_dir   = ~dir;
      bus_if.cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      check({name, " ready_while_busy"}, 32'(bus_if.cmd_ready), 32'd0);
      bus_if.cmd_valid = 1'b0;
    end

    if (abort_k >= 0) begin
      budget = 2000;
      while (obs_t.size() < abort_k && budget > 0) begin
        @(negedge clk);
        #1;
        budget--;
      end
      check({name, " abort_wait"}, 32'(obs_t.size() >= abort_k), 32'd1);
      repeat (abort_d - 1) @(negedge clk);
      bus_if.abort = 1'b1;
      @(negedge clk);
      bus_if.abort = 1'b0;
    end

    budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    repeat (3) @(negedge clk);
    #1;

    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " done_time"}, 32'(done_cyc - acc), 32'(exp_done_off));
    check({name, " step_count"}, 32'(obs_t.size()), 32'(exp_off.size()));
    m = (obs_t.size() < exp_off.size()) ? obs_t.size() : exp_off.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s step%0d_time", name, i + 1), 32'(obs_t[i] - acc), 32'(exp_off[i]));
      check($sformatf("%s step%0d_coils", name, i + 1), 32'(obs_coil[i]), 32'(exp_coil[i]));
    end
    check({name, " steps_done"}, 32'(bus_if.steps_done), 32'(exp_off.size()));
    check({name, " coils_hold"}, 32'(bus_if.coils), 32'(coil_tab[model_phase]));
    check({name, " idle_busy"}, 32'(bus_if.busy), 32'd0);
    check({name, " idle_ready"}, 32'(bus_if.cmd_ready), 32'd1);
  endtask

  initial begin
    int n, k, d;
    bit dr, hf, pk;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_steps = '0;
    bus_if.cmd_dir   = 1'b0;
    bus_if.cmd_half  = 1'b0;
    bus_if.abort     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset coils", 32'(bus_if.coils), 32'b1000);
    check("reset busy", 32'(bus_if.busy), 32'd0);
    check("reset ready", 32'(bus_if.cmd_ready), 32'd1);
    check("reset done", 32'(bus_if.done), 32'd0);
    check("reset steps_done", 32'(bus_if.steps_done), 32'd0);

    // Short half-step move: the ramp turns around after one step.
    run_move("m3_fwd_half", 3, 1'b1, 1'b1, -1, 0, 1'b0);

    // Full trapezoid from index 0; ends at index 4.
    do_reset();
    run_move("m20_fwd_half", 20, 1'b1, 1'b1, -1, 0, 1'b0);
    check("m20 final coils", 32'(bus_if.coils), 32'b0010);

    // Reverse full steps from index 0.
    do_reset();
    run_move("m2_rev_full", 2, 1'b0, 1'b0, -1, 0, 1'b0);
    check("m2 final coils", 32'(bus_if.coils), 32'b0010);

    // Zero-length move.
    run_move("m0", 0, 1'b1, 1'b0, -1, 0, 1'b0);

    // Abort during cruise, with a command offered while busy.
    run_move("abort_cruise", 20, 1'b1, 1'b1, 6, 2, 1'b1);
    // Abort in ACCEL after one step, and before any step.
    run_move("abort_accel1", 10, 1'b0, 1'b1, 1, 3, 1'b0);
    run_move("abort_accel0", 10, 1'b1, 1'b0, 0, 2, 1'b0);

    // Reset in the middle of ACCEL.
    @(negedge clk);
    done_cnt = 0;
    bus_if.cmd_steps = 16'd3;
    bus_if.cmd_dir   = 1'b1;
    bus_if.cmd_half  = 1'b1;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_phase = 0;
    check("midreset coils", 32'(bus_if.coils), 32'b1000);
    check("midreset busy", 32'(bus_if.busy), 32'd0);
    check("midreset ready", 32'(bus_if.cmd_ready), 32'd1);
    check("midreset steps_done", 32'(bus_if.steps_done), 32'd0);
    repeat (15) @(negedge clk);
    check("midreset no_done", 32'(done_cnt), 32'd0);
    run_move("after_reset", 3, 1'b1, 1'b1, -1, 0, 1'b0);

    // Random moves, some aborted and some poked while busy.
    for (int i = 0; i < 12; i++) begin
      n  = int'($urandom_range(0, 25));
      dr = 1'($urandom_range(0, 1));
      hf = 1'($urandom_range(0, 1));
      k  = -1;
      d  = 0;
      if (n > 0 && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, n - 1));
        d = int'($urandom_range(1, 3));
      end
      pk = (n > 0 && k != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_move($sformatf("rand%0d", i), n, dr, hf, k, d, pk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
